// File: rtl/elevator_req_scheduler.sv
// SCAN (collective, direction-preserving) request scheduler: gathers floor requests into a
// pending set and hands the next target floor to the elevator FSM.
module elevator_req_scheduler #(
   parameter  int FLOORS_NUM = 5,
   localparam int FW         = (FLOORS_NUM > 1) ? $clog2(FLOORS_NUM) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLOORS_NUM-1:0] floor_req,
   input  logic [FW-1:0]         curr_floor,
   input  logic [FLOORS_NUM-1:0] request_done,
   output logic [FW-1:0]         req_floor,
   output logic [FLOORS_NUM-1:0] pending,
   output logic                  dir_up,
   output logic                  dir_down,
   output logic                  ack_here
);

   typedef enum logic [1:0] {
      SCH_IDLE = 2'd0,
      SCH_UP   = 2'd1,
      SCH_DOWN = 2'd2
   } sch_state_t;

   sch_state_t            state_q, state_d;
   logic [FLOORS_NUM-1:0] pending_q, pending_d;
   logic [FW-1:0]         req_floor_q, req_floor_d;
   logic                  ack_here_q, ack_here_d;

   logic [FLOORS_NUM-1:0] idle_here;
   logic                  door_open;
   logic                  up_vld, dn_vld;
   logic [FW-1:0]         up_idx, dn_idx;
   logic [FW-1:0]         dist_up, dist_dn;

   assign door_open = (request_done != '0);

   // A request for the floor we are idling at is absorbed instead of becoming pending.
   always_comb begin
      idle_here = '0;
      for (int i = 0; i < FLOORS_NUM; i++) begin
         idle_here[i] = (state_q == SCH_IDLE) && !door_open && (curr_floor == FW'(i));
      end
   end

   // Descending scan leaves the lowest pending floor above curr_floor.
   always_comb begin
      up_vld = 1'b0;
      up_idx = '0;
      for (int i = FLOORS_NUM - 1; i >= 0; i--) begin
         if (pending_q[i] && (FW'(i) > curr_floor)) begin
            up_vld = 1'b1;
            up_idx = FW'(i);
         end
      end
   end

   // Ascending scan leaves the highest pending floor below curr_floor.
   always_comb begin
      dn_vld = 1'b0;
      dn_idx = '0;
      for (int i = 0; i < FLOORS_NUM; i++) begin
         if (pending_q[i] && (FW'(i) < curr_floor)) begin
            dn_vld = 1'b1;
            dn_idx = FW'(i);
         end
      end
   end

   assign dist_up = up_idx - curr_floor;
   assign dist_dn = curr_floor - dn_idx;

   always_comb begin
      pending_d  = (pending_q | floor_req) & ~request_done & ~idle_here;
      ack_here_d = |(floor_req & idle_here);
   end

   always_comb begin
      state_d     = state_q;
      req_floor_d = req_floor_q;
      if (door_open) begin
         // Pinning the target to the open-door floor keeps the FSM parked until we retarget.
         req_floor_d = curr_floor;
      end else begin
         case (state_q)
            SCH_IDLE: begin
               if (up_vld && dn_vld) begin
                  if (dist_dn < dist_up) begin
                     state_d     = SCH_DOWN;
                     req_floor_d = dn_idx;
                  end else begin
                     state_d     = SCH_UP;
                     req_floor_d = up_idx;
                  end
               end else if (up_vld) begin
                  state_d     = SCH_UP;
                  req_floor_d = up_idx;
               end else if (dn_vld) begin
                  state_d     = SCH_DOWN;
                  req_floor_d = dn_idx;
               end else begin
                  req_floor_d = curr_floor;
               end
            end
            SCH_UP: begin
               if (up_vld) begin
                  req_floor_d = up_idx;
               end else if (dn_vld) begin
                  state_d     = SCH_DOWN;
                  req_floor_d = dn_idx;
               end else begin
                  state_d     = SCH_IDLE;
                  req_floor_d = curr_floor;
               end
            end
            SCH_DOWN: begin
               if (dn_vld) begin
                  req_floor_d = dn_idx;
               end else if (up_vld) begin
                  state_d     = SCH_UP;
                  req_floor_d = up_idx;
               end else begin
                  state_d     = SCH_IDLE;
                  req_floor_d = curr_floor;
               end
            end
            default: begin
               state_d     = SCH_IDLE;
               req_floor_d = curr_floor;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCH_IDLE;
         pending_q   <= '0;
         req_floor_q <= '0;
         ack_here_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         req_floor_q <= req_floor_d;
         ack_here_q  <= ack_here_d;
      end
   end

   assign req_floor = req_floor_q;
   assign pending   = pending_q;
   assign dir_up    = (state_q == SCH_UP);
   assign dir_down  = (state_q == SCH_DOWN);
   assign ack_here  = ack_here_q;

endmodule

// File: tb/tb_elevator_req_scheduler.sv
// Scenario bench for elevator_req_scheduler: each row drives one cycle of inputs and queues
// the outputs expected after that edge as {pending, req_floor, dir_up, dir_down, ack_here}.
module tb_elevator_req_scheduler;

   localparam int N  = 5;
   localparam int FW = 3;
   localparam int W  = N + FW + 3;

   typedef struct packed {
      logic          rst;
      logic [N-1:0]  freq;
      logic [FW-1:0] curr;
      logic [N-1:0]  done;
      logic [W-1:0]  exp;
   } row_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  floor_req;
   logic [FW-1:0] curr_floor;
   logic [N-1:0]  request_done;
   logic [FW-1:0] req_floor;
   logic [N-1:0]  pending;
   logic          dir_up;
   logic          dir_down;
   logic          ack_here;

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;

   elevator_req_scheduler #(.FLOORS_NUM(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .floor_req    (floor_req),
      .curr_floor   (curr_floor),
      .request_done (request_done),
      .req_floor    (req_floor),
      .pending      (pending),
      .dir_up       (dir_up),
      .dir_down     (dir_down),
      .ack_here     (ack_here)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- row builders ----------------
   function automatic logic [W-1:0] ev(input logic [N-1:0] p, input logic [FW-1:0] rq,
                                       input logic u, input logic d, input logic a);
      return {p, rq, u, d, a};
   endfunction

   function automatic row_t mk(input logic r, input logic [N-1:0] f, input logic [FW-1:0] c,
                               input logic [N-1:0] dn, input logic [W-1:0] e);
      row_t x;
      x.rst = r; x.freq = f; x.curr = c; x.done = dn; x.exp = e;
      return x;
   endfunction

   // ---------------- driver ----------------
   task automatic drive_cycle(input row_t r);
      rst          = r.rst;
      floor_req    = r.freq;
      curr_floor   = r.curr;
      request_done = r.done;
      exp_q.push_back(r.exp);
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      row_t r[$];
      logic [W-1:0] e, obs;
      r.push_back(mk(1, 5'b11111, 3'd3, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(1, 5'b00000, 3'd0, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      foreach (r[i]) begin
         drive_cycle(r[i]);
         e   = exp_q.pop_front();
         obs = {pending, req_floor, dir_up, dir_down, ack_here};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset[%0d]: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_first_request();
      row_t r[$];
      logic [W-1:0] e, obs;
      r.push_back(mk(1, 5'b00000, 3'd0, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b01000, 3'd0, 5'b00000, ev(5'b01000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd0, 5'b00000, ev(5'b01000, 3'd3, 1, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd0, 5'b00000, ev(5'b01000, 3'd3, 1, 0, 0)));
      foreach (r[i]) begin
         drive_cycle(r[i]);
         e   = exp_q.pop_front();
         obs = {pending, req_floor, dir_up, dir_down, ack_here};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL first_request[%0d]: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_retarget();
      row_t r[$];
      logic [W-1:0] e, obs;
      r.push_back(mk(1, 5'b00000, 3'd0, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b10000, 3'd0, 5'b00000, ev(5'b10000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd0, 5'b00000, ev(5'b10000, 3'd4, 1, 0, 0)));
      r.push_back(mk(0, 5'b00100, 3'd1, 5'b00000, ev(5'b10100, 3'd4, 1, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd1, 5'b00000, ev(5'b10100, 3'd2, 1, 0, 0)));
      // door at 2 with a fresh request for 2 in the same cycle: clear wins
      r.push_back(mk(0, 5'b00100, 3'd2, 5'b00100, ev(5'b10000, 3'd2, 1, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd2, 5'b00100, ev(5'b10000, 3'd2, 1, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd2, 5'b00000, ev(5'b10000, 3'd4, 1, 0, 0)));
      foreach (r[i]) begin
         drive_cycle(r[i]);
         e   = exp_q.pop_front();
         obs = {pending, req_floor, dir_up, dir_down, ack_here};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL retarget[%0d]: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_reverse_sweep();
      row_t r[$];
      logic [W-1:0] e, obs;
      r.push_back(mk(1, 5'b00000, 3'd0, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b10000, 3'd0, 5'b00000, ev(5'b10000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd0, 5'b00000, ev(5'b10000, 3'd4, 1, 0, 0)));
      r.push_back(mk(0, 5'b00010, 3'd2, 5'b00000, ev(5'b10010, 3'd4, 1, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd3, 5'b00000, ev(5'b10010, 3'd4, 1, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd4, 5'b10000, ev(5'b00010, 3'd4, 1, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd4, 5'b00000, ev(5'b00010, 3'd1, 0, 1, 0)));
      r.push_back(mk(0, 5'b00000, 3'd3, 5'b00000, ev(5'b00010, 3'd1, 0, 1, 0)));
      r.push_back(mk(0, 5'b00000, 3'd1, 5'b00010, ev(5'b00000, 3'd1, 0, 1, 0)));
      r.push_back(mk(0, 5'b00000, 3'd1, 5'b00000, ev(5'b00000, 3'd1, 0, 0, 0)));
      foreach (r[i]) begin
         drive_cycle(r[i]);
         e   = exp_q.pop_front();
         obs = {pending, req_floor, dir_up, dir_down, ack_here};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reverse_sweep[%0d]: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_idle_ack();
      row_t r[$];
      logic [W-1:0] e, obs;
      logic [FW-1:0] f;
      logic [N-1:0] oh;
      r.push_back(mk(1, 5'b00000, 3'd2, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd2, 5'b00000, ev(5'b00000, 3'd2, 0, 0, 0)));
      r.push_back(mk(0, 5'b00100, 3'd2, 5'b00000, ev(5'b00000, 3'd2, 0, 0, 1)));
      r.push_back(mk(0, 5'b00000, 3'd2, 5'b00000, ev(5'b00000, 3'd2, 0, 0, 0)));
      for (int k = 0; k < 4; k++) begin
         f  = FW'($urandom_range(0, N - 1));
         oh = N'(1) << f;
         r.push_back(mk(0, 5'b00000, f, 5'b00000, ev(5'b00000, f, 0, 0, 0)));
         r.push_back(mk(0, oh,       f, 5'b00000, ev(5'b00000, f, 0, 0, 1)));
      end
      foreach (r[i]) begin
         drive_cycle(r[i]);
         e   = exp_q.pop_front();
         obs = {pending, req_floor, dir_up, dir_down, ack_here};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL idle_ack[%0d]: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_nearest_and_tie();
      row_t r[$];
      logic [W-1:0] e, obs;
      // curr=1: floor 0 is one away, floor 4 three away -> down
      r.push_back(mk(1, 5'b00000, 3'd1, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b10001, 3'd1, 5'b00000, ev(5'b10001, 3'd1, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd1, 5'b00000, ev(5'b10001, 3'd0, 0, 1, 0)));
      // curr=2: equidistant -> up
      r.push_back(mk(1, 5'b00000, 3'd2, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b10001, 3'd2, 5'b00000, ev(5'b10001, 3'd2, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd2, 5'b00000, ev(5'b10001, 3'd4, 1, 0, 0)));
      // curr=3: floor 4 one away, floor 0 three away -> up
      r.push_back(mk(1, 5'b00000, 3'd3, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b10001, 3'd3, 5'b00000, ev(5'b10001, 3'd3, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd3, 5'b00000, ev(5'b10001, 3'd4, 1, 0, 0)));
      foreach (r[i]) begin
         drive_cycle(r[i]);
         e   = exp_q.pop_front();
         obs = {pending, req_floor, dir_up, dir_down, ack_here};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL nearest_tie[%0d]: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_reset_mid_travel();
      row_t r[$];
      logic [W-1:0] e, obs;
      r.push_back(mk(1, 5'b00000, 3'd0, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b11010, 3'd0, 5'b00000, ev(5'b11010, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd0, 5'b00000, ev(5'b11010, 3'd1, 1, 0, 0)));
      r.push_back(mk(1, 5'b00100, 3'd1, 5'b00000, ev(5'b00000, 3'd0, 0, 0, 0)));
      r.push_back(mk(0, 5'b00000, 3'd1, 5'b00000, ev(5'b00000, 3'd1, 0, 0, 0)));
      foreach (r[i]) begin
         drive_cycle(r[i]);
         e   = exp_q.pop_front();
         obs = {pending, req_floor, dir_up, dir_down, ack_here};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid_travel[%0d]: got %b required %b", i, obs, e);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst          = 1'b1;
      floor_req    = '0;
      curr_floor   = '0;
      request_done = '0;
      #2;
      test_reset();
      test_first_request();
      test_retarget();
      test_reverse_sweep();
      test_idle_ack();
      test_nearest_and_tie();
      test_reset_mid_travel();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
